// File: rtl/switch_ctrl_pkg.sv
// Shared types and constants for the switch/button input conditioning block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package switch_ctrl_pkg;

    // Per-button debounce FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    // Edges a fresh snapshot is protected from being overwritten by another grant.
    localparam int SNAPSHOT_LOCK_CYCLES    = 2;
    // Debounce counter width; holds DEBOUNCE_CYCLES-1 for the whole legal range.
    localparam int DB_CNT_W                = 16;

endpackage

// File: rtl/button_debounce.sv
// Purpose: 2-flop synchroniser + debounce FSM for one button; press acceptance waits for a grant.
// Latency: PRESSED D+3 edges after a stable raw rise (uncontested); release likewise D+3 edges.
// Backpressure: without grant_i the FSM holds in PRESS_WAIT with req_o asserted; release is never held.
// Ports: HCLK/HRESETn clock and async active-low reset; raw_i bouncy pad; grant_i press grant;
//        req_o press ready to be accepted; level_o debounced level (state is PRESSED or RELEASE_WAIT).
`timescale 1ns/1ps
module button_debounce
    import switch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic raw_i,
    input  logic grant_i,
    output logic req_o,
    output logic level_o
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q;
    logic                sync2_q;
    db_state_t           state_q, state_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                cnt_done;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (!cnt_done) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (grant_i) begin
                    state_d = PRESSED;
                end
                // cnt_done without grant: counter stays saturated, request stays up.
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                end else if (!cnt_done) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_o   = (state_q == PRESS_WAIT) && cnt_done && sync2_q;
    assign level_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/switch_input_ctrl.sv
// Purpose: synchronise switches, debounce two buttons, arbitrate presses so Switches is frozen around each Buttons rise.
// Latency: Buttons follows raw pads by DEBOUNCE_CYCLES+4 edges; Switches snapshot loads one edge before the Buttons rise.
// Backpressure: a press waits while another press' snapshot is locked (2 edges); button 0 has priority.
// Ports: HCLK, HRESETn (async active-low); RawButtons[1:0], RawSwitches[15:0] raw pads; IrqAck clears Irq;
//        Buttons[1:0] clean levels; Switches[15:0] snapshot; Irq sticky new-entry interrupt.
// Build option: define SWITCH_INPUT_IRQ_EN to build the Irq flop; otherwise Irq is tied low.
`timescale 1ns/1ps
module switch_input_ctrl
    import switch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  RawButtons,
    input  logic [15:0] RawSwitches,
    input  logic        IrqAck,
    output logic [1:0]  Buttons,
    output logic [15:0] Switches,
    output logic        Irq
);

    localparam logic [1:0] LOCK_INIT = 2'(SNAPSHOT_LOCK_CYCLES);

    logic [15:0] sw_sync1_q;
    logic [15:0] sw_sync2_q;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic [1:0]  level;
    logic        lock;
    logic [1:0]  lock_cnt_q, lock_cnt_d;
    logic [15:0] switches_q, switches_d;
    logic [1:0]  buttons_q;

    for (genvar i = 0; i < 2; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .raw_i   (RawButtons[i]),
            .grant_i (grant[i]),
            .req_o   (req[i]),
            .level_o (level[i])
        );
    end

    // Fixed priority, at most one grant per cycle, none while a snapshot is locked.
    assign lock     = (lock_cnt_q != 2'd0);
    assign grant[0] = req[0] & ~lock;
    assign grant[1] = req[1] & ~req[0] & ~lock;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        switches_d = switches_q;
        if (|grant) begin
            lock_cnt_d = LOCK_INIT;
            switches_d = sw_sync2_q;
        end else if (lock) begin
            lock_cnt_d = lock_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            lock_cnt_q <= '0;
            switches_q <= '0;
            buttons_q  <= '0;
        end else begin
            sw_sync1_q <= RawSwitches;
            sw_sync2_q <= sw_sync1_q;
            lock_cnt_q <= lock_cnt_d;
            switches_q <= switches_d;
            buttons_q  <= level;
        end
    end

    assign Buttons  = buttons_q;
    assign Switches = switches_q;

`ifdef SWITCH_INPUT_IRQ_EN
    logic irq_q, irq_d;

    // A Buttons rise on this edge wins over a simultaneous acknowledge.
    always_comb begin
        irq_d = irq_q;
        if (IrqAck) begin
            irq_d = 1'b0;
        end
        if (|(level & ~buttons_q)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign Irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = IrqAck;
    assign Irq            = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_ctrl.sv
`timescale 1ns/1ps
module tb_switch_input_ctrl;

    localparam int D = 4;
`ifdef SWITCH_INPUT_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  RawButtons;
    logic [15:0] RawSwitches;
    logic        IrqAck;
    logic [1:0]  Buttons;
    logic [15:0] Switches;
    logic        Irq;

    int total = 0;
    int bad   = 0;

    switch_input_ctrl #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .RawButtons  (RawButtons),
        .RawSwitches (RawSwitches),
        .IrqAck      (IrqAck),
        .Buttons     (Buttons),
        .Switches    (Switches),
        .Irq         (Irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Reference model: each button keeps an accepted level and a run length of
    // consecutive synchronised samples disagreeing with it. A disagreement seen
    // on D+1 consecutive edges flips the level; a press flip additionally needs
    // to win arbitration (button 0 first, >=3 edges since the previous press).
    logic [1:0]  m_s1, m_s2;
    logic [15:0] m_w1, m_w2;
    logic [1:0]  m_acc;
    int          m_run [2];
    logic [1:0]  m_btn;
    logic [15:0] m_sw;
    logic        m_irq;
    int          m_since;
    int          rn [2];
    int          g;
    logic [1:0]  nb;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_s1 = '0; m_s2 = '0; m_w1 = '0; m_w2 = '0;
            m_acc = '0; m_run[0] = 0; m_run[1] = 0;
            m_btn = '0; m_sw = '0; m_irq = 1'b0; m_since = 3;
        end else begin
            for (int i = 0; i < 2; i++)
                rn[i] = (m_s2[i] != m_acc[i]) ? ((m_run[i] < D + 1) ? m_run[i] + 1 : D + 1) : 0;
            nb = m_acc;
            m_since = (m_since < 3) ? m_since + 1 : 3;
            g = -1;
            if (m_since >= 3) begin
                if (!m_acc[0] && rn[0] >= D + 1)      g = 0;
                else if (!m_acc[1] && rn[1] >= D + 1) g = 1;
            end
            if (g >= 0) begin
                m_sw    = m_w2;
                m_since = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (rn[i] >= D + 1 && (m_acc[i] || g == i)) begin
                    m_acc[i] = ~m_acc[i];
                    m_run[i] = 0;
                end else begin
                    m_run[i] = rn[i];
                end
            end
`ifdef SWITCH_INPUT_IRQ_EN
            if ((nb & ~m_btn) != 2'b00) m_irq = 1'b1;
            else if (IrqAck)            m_irq = 1'b0;
`endif
            m_btn = nb;
            m_s2 = m_s1; m_s1 = RawButtons;
            m_w2 = m_w1; m_w1 = RawSwitches;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge and compare all outputs against the model.
    task automatic step();
        @(posedge HCLK);
        #1;
        chk("model_btn", 32'(Buttons), 32'(m_btn));
        chk("model_sw",  32'(Switches), 32'(m_sw));
        chk("model_irq", 32'(Irq), 32'(m_irq));
    endtask

    initial begin
        HRESETn = 1'b0; RawButtons = '0; RawSwitches = '0; IrqAck = 1'b0;
        #2;
        chk("rst_btn", 32'(Buttons), 32'h0);
        chk("rst_sw",  32'(Switches), 32'h0);
        chk("rst_irq", 32'(Irq), 32'h0);
        step(); step();
        HRESETn = 1'b1;

        // Basic press latency with a snapshot.
        RawSwitches = 16'hA5A5; RawButtons = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 7) chk("t1_sw_e7", 32'(Switches), 32'hA5A5);
            if (e < 8)  chk("t1_btn_pre", 32'(Buttons), 32'h0);
            else        chk("t1_btn_e8", 32'(Buttons), 32'h1);
        end
        RawButtons = 2'b00;
        for (int e = 1; e <= D + 4; e++) begin
            step();
            if (e == D + 3) chk("t1_rel_hold", 32'(Buttons), 32'h1);
            if (e == D + 4) chk("t1_rel_fall", 32'(Buttons), 32'h0);
        end
        IrqAck = 1'b1; step(); IrqAck = 1'b0;

        // Button 1 bouncing with 2-cycle pulses.
        for (int k = 0; k < 8; k++) begin
            RawButtons = {(k % 4) < 2, 1'b0};
            step();
            chk("t2_btn", 32'(Buttons), 32'h0);
        end
        RawButtons = 2'b00;
        repeat (6) step();
        chk("t2_btn_end", 32'(Buttons), 32'h0);
        chk("t2_sw_end", 32'(Switches), 32'hA5A5);

        // Simultaneous press: button 1 deferred by the lock, fresh snapshot.
        RawButtons = 2'b11;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e == 7)  RawSwitches = 16'h1234;
            if (e == 8)  chk("t3_btn0_rise", 32'(Buttons), 32'h1);
            if (e == 8)  chk("t3_sw_old", 32'(Switches), 32'hA5A5);
            if (e == 10) chk("t3_sw_new", 32'(Switches), 32'h1234);
            if (e == 10) chk("t3_btn1_wait", 32'(Buttons), 32'h1);
            if (e == 11) chk("t3_btn1_rise", 32'(Buttons), 32'h3);
        end
        RawButtons = 2'b00;
        repeat (12) step();
        IrqAck = 1'b1; step(); IrqAck = 1'b0;

        // Release with a one-cycle glitch inside RELEASE_WAIT.
        RawButtons = 2'b01;
        repeat (10) step();
        RawButtons = 2'b00;
        step(); step(); step();
        RawButtons = 2'b01;
        step();
        RawButtons = 2'b00;
        for (int e = 5; e <= 12; e++) begin
            step();
            if (e < 12) chk("t4_btn_held", 32'(Buttons), 32'h1);
            else        chk("t4_btn_fall", 32'(Buttons), 32'h0);
        end
        IrqAck = 1'b1; step(); IrqAck = 1'b0;
        repeat (4) step();

        // Reset while button 0 sits in PRESS_WAIT.
        RawButtons = 2'b01;
        repeat (4) step();
        HRESETn = 1'b0;
        #1;
        chk("t5_rst_btn", 32'(Buttons), 32'h0);
        chk("t5_rst_sw", 32'(Switches), 32'h0);
        chk("t5_rst_irq", 32'(Irq), 32'h0);
        step(); step();
        HRESETn = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 7) chk("t5_sw_e7", 32'(Switches), 32'h1234);
            if (e < 8)  chk("t5_btn_pre", 32'(Buttons), 32'h0);
            else        chk("t5_btn_e8", 32'(Buttons), 32'h1);
        end
        chk("t6_irq_set", 32'(Irq), 32'(IRQ_ON));
        IrqAck = 1'b1; step(); IrqAck = 1'b0;
        chk("t6_irq_ack", 32'(Irq), 32'h0);
        RawButtons = 2'b00;
        repeat (10) step();

        // Ack coincident with a button 1 rise.
        RawButtons = 2'b10;
        for (int e = 1; e <= 8; e++) begin
            if (e == 8) IrqAck = 1'b1;
            step();
        end
        IrqAck = 1'b0;
        chk("t6_btn1", 32'(Buttons), 32'h2);
        chk("t6_irq_win", 32'(Irq), 32'(IRQ_ON));
        RawButtons = 2'b00;
        repeat (10) step();

        // Random segments, occasional reset pulses.
        for (int seg = 0; seg < 400; seg++) begin
            int hold;
            RawButtons  = 2'($urandom);
            RawSwitches = 16'($urandom);
            hold = $urandom_range(1, 2 * D + 4);
            for (int h = 0; h < hold; h++) begin
                IrqAck  = ($urandom_range(0, 7) == 0);
                HRESETn = ($urandom_range(0, 299) != 0);
                step();
            end
        end
        HRESETn = 1'b1;
        IrqAck  = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
